// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU slice.
//   op_t    - operation codes carried on the 3-bit op bus (5..7 yield zero)
//   state_t - control FSM states
//   add_sub_ovf() - signed overflow from operand/result sign bits
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_MUL = 3'd2,
    OP_DIV = 3'd3,
    OP_MOD = 3'd4
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  // Subtraction is addition of the negated operand, so its effective
  // sign is the inverted sign of B.
  function automatic logic add_sub_ovf(input logic sa, input logic sb,
                                       input logic sr, input logic is_sub);
    logic sb_eff;
    sb_eff = sb ^ is_sub;
    return (sa == sb_eff) && (sr != sa);
  endfunction

endpackage

// File: rtl/seq_alu_if.sv
// seq_alu_if: operation request / result bus of seq_alu.
//   start, op, tmp1, tmp2, oe            - driven by the controller (master)
//   busy, done, result, zero, carry,
//   sign, div_zero                       - driven by the ALU (slave)
interface seq_alu_if #(
  parameter int WIDTH = 16
) ();

  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] tmp1;
  logic [WIDTH-1:0] tmp2;
  logic             oe;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             sign;
  logic             div_zero;

  modport master (
    output start, op, tmp1, tmp2, oe,
    input  busy, done, result, zero, carry, sign, div_zero
  );

  modport slave (
    input  start, op, tmp1, tmp2, oe,
    output busy, done, result, zero, carry, sign, div_zero
  );

endinterface

// File: rtl/seq_alu_iter.sv
// seq_alu_iter: unsigned magnitude datapath, one bit per step.
//   clk, reset     - clock, synchronous active-high reset
//   load           - load a_mag into acc_lo, b_mag into the operand reg, clear acc_hi
//   step           - perform one shift-add (is_div=0) or restoring-divide (is_div=1) step
//   a_mag, b_mag   - operand magnitudes
//   acc_hi, acc_lo - multiply: {acc_hi,acc_lo} is the 2*WIDTH product;
//                    divide: acc_lo is the quotient, acc_hi the remainder
module seq_alu_iter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a_mag,
  input  logic [WIDTH-1:0] b_mag,
  output logic [WIDTH-1:0] acc_hi,
  output logic [WIDTH-1:0] acc_lo
);

  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   part;
  logic [WIDTH-1:0] trial;
  logic             ge;

  always_comb begin
    // Multiply: add the multiplicand when the current multiplier bit is set;
    // the carry shifts back into acc_hi on the right shift.
    add_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, b_q} : '0);
    // Divide: bring the next dividend bit into the partial remainder.
    part    = {acc_hi, acc_lo[WIDTH-1]};
    ge      = (part >= {1'b0, b_q});
    // Only used when ge, where the difference is below b_q and fits WIDTH bits.
    trial   = part[WIDTH-1:0] - b_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_hi <= '0;
      acc_lo <= '0;
      b_q    <= '0;
    end else if (load) begin
      acc_hi <= '0;
      acc_lo <= a_mag;
      b_q    <= b_mag;
    end else if (step) begin
      if (is_div) begin
        acc_hi <= ge ? trial : part[WIDTH-1:0];
        acc_lo <= {acc_lo[WIDTH-2:0], ge};
      end else begin
        acc_hi <= add_sum[WIDTH:1];
        acc_lo <= {add_sum[0], acc_lo[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle signed ALU with start/busy/done handshake.
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high; aborts any operation, clears outputs
//   bus    - seq_alu_if.slave: start/op/tmp1/tmp2/oe in,
//            busy/done/result/zero/carry/sign/div_zero out
// add/sub/other ops and divide-by-zero complete on the accepting edge;
// mul/div/mod iterate WIDTH steps in seq_alu_iter, then a FIX cycle applies
// the sign. Define SEQ_ALU_FAST_MUL_EN to move mul onto the single-cycle path.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic     clk,
  input  logic     reset,
  seq_alu_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t           state_q, state_d;
  op_t              op_q;
  logic             a_neg_q, b_neg_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] res_q;
  logic             zero_q, carry_q, sign_q, dz_q, done_q;

  logic             accept, it_load, it_step, last_step;
  logic             iter_op;
  logic [WIDTH-1:0] sc_res;
  logic             sc_carry, sc_dz;
  logic [WIDTH-1:0] sum, diff;
  logic [WIDTH-1:0] a_mag, b_mag;

  logic [WIDTH-1:0]   acc_hi, acc_lo;
  logic               res_neg;
  logic [2*WIDTH-1:0] prod_signed;
  logic [WIDTH-1:0]   fx_res;
  logic               fx_carry;

  // Full signed product fits WIDTH bits only if its upper WIDTH+1 bits
  // are a pure sign extension.
  function automatic logic prod_ovf(input logic [2*WIDTH-1:0] p);
    return !((p[2*WIDTH-1:WIDTH-1] == '0) || (p[2*WIDTH-1:WIDTH-1] == '1));
  endfunction

  // ---------------------------------------------------------------
  // Single-cycle path: evaluated on the live bus operands at accept
  // ---------------------------------------------------------------
`ifdef SEQ_ALU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = $signed({{WIDTH{bus.tmp1[WIDTH-1]}}, bus.tmp1})
                   * $signed({{WIDTH{bus.tmp2[WIDTH-1]}}, bus.tmp2});
`endif

  always_comb begin
    sc_res   = '0;
    sc_carry = 1'b0;
    sc_dz    = 1'b0;
    iter_op  = 1'b0;
    sum      = bus.tmp1 + bus.tmp2;
    diff     = bus.tmp1 - bus.tmp2;
    case (op_t'(bus.op))
      OP_ADD: begin
        sc_res   = sum;
        sc_carry = add_sub_ovf(bus.tmp1[WIDTH-1], bus.tmp2[WIDTH-1],
                               sum[WIDTH-1], 1'b0);
      end
      OP_SUB: begin
        sc_res   = diff;
        sc_carry = add_sub_ovf(bus.tmp1[WIDTH-1], bus.tmp2[WIDTH-1],
                               diff[WIDTH-1], 1'b1);
      end
      OP_MUL: begin
`ifdef SEQ_ALU_FAST_MUL_EN
        sc_res   = fast_prod[WIDTH-1:0];
        sc_carry = prod_ovf(fast_prod);
`else
        iter_op  = 1'b1;
`endif
      end
      OP_DIV: begin
        if (bus.tmp2 == '0) sc_dz = 1'b1;
        else                iter_op = 1'b1;
      end
      OP_MOD: begin
        if (bus.tmp2 == '0) begin
          sc_res = bus.tmp1;
          sc_dz  = 1'b1;
        end else begin
          iter_op = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign a_mag = bus.tmp1[WIDTH-1] ? ('0 - bus.tmp1) : bus.tmp1;
  assign b_mag = bus.tmp2[WIDTH-1] ? ('0 - bus.tmp2) : bus.tmp2;

  // ---------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    it_load = 1'b0;
    it_step = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          accept = 1'b1;
          if (iter_op) begin
            it_load = 1'b1;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        it_step = 1'b1;
        if (last_step) state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  seq_alu_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk    (clk),
    .reset  (reset),
    .load   (it_load),
    .step   (it_step),
    .is_div (op_q != OP_MUL),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo)
  );

  // ---------------------------------------------------------------
  // Sign fix-up of the magnitude results
  // ---------------------------------------------------------------
  always_comb begin
    fx_res      = '0;
    fx_carry    = 1'b0;
    res_neg     = a_neg_q ^ b_neg_q;
    prod_signed = res_neg ? ('0 - {acc_hi, acc_lo}) : {acc_hi, acc_lo};
    case (op_q)
      OP_MUL: begin
        fx_res   = prod_signed[WIDTH-1:0];
        fx_carry = prod_ovf(prod_signed);
      end
      OP_DIV: begin
        fx_res   = res_neg ? ('0 - acc_lo) : acc_lo;
        // Only a positive quotient of magnitude 2^(WIDTH-1) (MIN / -1)
        // is unrepresentable.
        fx_carry = !res_neg && acc_lo[WIDTH-1];
      end
      OP_MOD: fx_res = a_neg_q ? ('0 - acc_hi) : acc_hi;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------
  // Operation latch, counter, result and flag registers
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= OP_ADD;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      sign_q  <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        op_q    <= op_t'(bus.op);
        a_neg_q <= bus.tmp1[WIDTH-1];
        b_neg_q <= bus.tmp2[WIDTH-1];
        cnt_q   <= '0;
        dz_q    <= sc_dz;
        if (!iter_op) begin
          res_q   <= sc_res;
          carry_q <= sc_carry;
          zero_q  <= (sc_res == '0);
          sign_q  <= sc_res[WIDTH-1];
          done_q  <= 1'b1;
        end
      end else if (state_q == ST_CALC) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end else if (state_q == ST_FIX) begin
        res_q   <= fx_res;
        carry_q <= fx_carry;
        zero_q  <= (fx_res == '0);
        sign_q  <= fx_res[WIDTH-1];
        done_q  <= 1'b1;
      end
    end
  end

  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.done     = done_q;
  assign bus.result   = bus.oe ? res_q : '0;
  assign bus.zero     = zero_q;
  assign bus.carry    = carry_q;
  assign bus.sign     = sign_q;
  assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and random checks of seq_alu against an integer
// reference model (WIDTH=16).
module tb_seq_alu;
  import alu_pkg::*;

  localparam int W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: signed integer arithmetic, then wrap to W bits.
  // lat = clock edges after the accepting edge until done is visible.
  function automatic void model(input logic [2:0] o, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] r,
                                output logic c, output logic dz, output int lat);
    longint sa, sb, full, maxv, minv;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    maxv = (longint'(1) <<< (W - 1)) - 1;
    minv = -(longint'(1) <<< (W - 1));
    full = 0;
    dz   = 1'b0;
    lat  = 0;
    case (o)
      3'd0: full = sa + sb;
      3'd1: full = sa - sb;
      3'd2: begin
        full = sa * sb;
`ifndef SEQ_ALU_FAST_MUL_EN
        lat = W + 1;
`endif
      end
      3'd3: begin
        if (sb == 0) dz = 1'b1;
        else begin full = sa / sb; lat = W + 1; end
      end
      3'd4: begin
        if (sb == 0) begin full = sa; dz = 1'b1; end
        else begin full = sa % sb; lat = W + 1; end
      end
      default: full = 0;
    endcase
    r = full[W-1:0];
    c = (o <= 3'd3) && ((full > maxv) || (full < minv));
  endfunction

  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = o;
    bus.tmp1  = a;
    bus.tmp2  = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int edges, output int busy_cyc, output logic seen);
    edges    = 0;
    busy_cyc = 0;
    while (!bus.done && edges < 100) begin
      if (bus.busy) busy_cyc++;
      @(posedge clk);
      #1;
      edges++;
    end
    seen = bus.done;
  endtask

  task automatic run_check(input string name, input logic [2:0] o,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] er;
    logic ec, edz, seen;
    int elat, edges, bcyc;
    model(o, a, b, er, ec, edz, elat);
    issue(o, a, b);
    wait_done(edges, bcyc, seen);
    chk({name, ".done"}, seen, 1'b1);
    chk({name, ".result"}, bus.result, er);
    chk({name, ".carry"}, bus.carry, ec);
    chk({name, ".zero"}, bus.zero, (er == '0));
    chk({name, ".sign"}, bus.sign, er[W-1]);
    chk({name, ".div_zero"}, bus.div_zero, edz);
    chk({name, ".latency"}, edges, elat);
    // busy is seen after each edge from the accepting one through FIX
    chk({name, ".busy_cycles"}, bcyc, elat);
    chk({name, ".busy_in_done"}, bus.busy, 1'b0);
    @(posedge clk);
    #1;
    chk({name, ".done_pulse"}, bus.done, 1'b0);
    chk({name, ".hold"}, bus.result, er);
  endtask

  task automatic chk_cleared(input string name);
    chk({name, ".busy"}, bus.busy, 1'b0);
    chk({name, ".done"}, bus.done, 1'b0);
    chk({name, ".result"}, bus.result, 16'h0);
    chk({name, ".zero"}, bus.zero, 1'b0);
    chk({name, ".carry"}, bus.carry, 1'b0);
    chk({name, ".sign"}, bus.sign, 1'b0);
    chk({name, ".div_zero"}, bus.div_zero, 1'b0);
  endtask

  initial begin
    logic [W-1:0] er, ra, rb;
    logic ec, edz;
    int elat, ndone;
    logic [2:0] ro;

    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.tmp1  = '0;
    bus.tmp2  = '0;
    bus.oe    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_cleared("reset");

    run_check("add_ovf",  3'd0, 16'h7FFF, 16'h0001);
    run_check("mul_neg",  3'd2, 16'hFFFD, 16'h0007);
    run_check("mul_ovf",  3'd2, 16'h0100, 16'h0100);
    run_check("div_neg",  3'd3, 16'hFFF9, 16'h0002);
    run_check("mod_neg",  3'd4, 16'hFFF9, 16'h0002);
    run_check("div_min",  3'd3, 16'h8000, 16'hFFFF);
    run_check("mod_min",  3'd4, 16'h8000, 16'hFFFF);
    run_check("div_by0",  3'd3, 16'h0005, 16'h0000);
    run_check("add_after_dz", 3'd0, 16'h0001, 16'h0001);
    run_check("mod_by0",  3'd4, 16'hFFF0, 16'h0000);
    run_check("sub_ovf",  3'd1, 16'h8000, 16'h0001);
    run_check("div_pos_neg", 3'd3, 16'h0007, 16'hFFFE);
    run_check("op_other", 3'd6, 16'h1234, 16'h5678);

    // Starts while busy are ignored; operands are latched at accept.
    model(3'd3, 16'd1000, 16'd7, er, ec, edz, elat);
    issue(3'd3, 16'd1000, 16'd7);
    ndone = 0;
    for (int e = 1; e <= W + 1; e++) begin
      bus.start = (e == 3 || e == 8);
      bus.op    = 3'd0;
      bus.tmp1  = 16'd50 + 16'(e);
      bus.tmp2  = 16'd9;
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    bus.start = 1'b0;
    chk("busy_start.done_count", ndone, 1);
    chk("busy_start.done_now", bus.done, 1'b1);
    chk("busy_start.result", bus.result, er);
    // start raised in the done cycle is accepted
    bus.start = 1'b1;
    bus.op    = 3'd0;
    bus.tmp1  = 16'd3;
    bus.tmp2  = 16'd4;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("done_cycle_start.done", bus.done, 1'b1);
    chk("done_cycle_start.result", bus.result, 16'd7);
    ndone = 0;
    repeat (W + 4) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    chk("busy_start.no_extra_done", ndone, 0);

    // Reset during CALC aborts the operation.
    issue(3'd2, 16'd123, 16'd45);
    repeat (5) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk_cleared("mid_reset");
    ndone = 0;
    repeat (W + 4) begin
      @(posedge clk);
      #1;
      if (bus.done) ndone++;
    end
    chk("mid_reset.no_done", ndone, 0);

    // Output enable gates the result only.
    run_check("mul_4x4", 3'd2, 16'd4, 16'd4);
    bus.oe = 1'b0;
    #1;
    chk("oe_low.result", bus.result, 16'h0);
    chk("oe_low.zero", bus.zero, 1'b0);
    bus.oe = 1'b1;
    #1;
    chk("oe_high.result", bus.result, 16'd16);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = 16'($urandom);
      rb = 16'($urandom);
      case ($urandom_range(0, 7))
        0: rb = 16'h0000;
        1: rb = 16'hFFFF;
        2: ra = 16'h8000;
        3: rb = 16'($urandom_range(1, 20));
        default: ;
      endcase
      run_check($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
